// File: rtl/hb_dual_sched_if.sv
`default_nettype none
// ============================================================================
//  Module   : hb_dual_sched_if
//  Purpose  : Stream bundle between the front-end decimation chain, the
//             shared halfband scheduler and the karaoke processing path.
//             Two input sample streams (L/R) go in. One tagged, decimated
//             output stream and status flags come out.
//  Signals  : x_l / x_l_valid   left Q15 sample and accept strobe
//             x_r / x_r_valid   right Q15 sample and accept strobe
//             y_out / y_valid   decimated Q15 result and one-cycle strobe
//             y_ch              channel of y_out (0 = L, 1 = R)
//             busy              scheduler not idle
//             overrun[1:0]      sticky per-channel overrun (bit0 = L)
//  Modports : master = sample source / result sink, slave = scheduler
//  Revision : 1.0  initial release
// ============================================================================
interface hb_dual_sched_if;
  logic signed [15:0] x_l;
  logic               x_l_valid;
  logic signed [15:0] x_r;
  logic               x_r_valid;
  logic signed [15:0] y_out;
  logic               y_valid;
  logic               y_ch;
  logic               busy;
  logic        [1:0]  overrun;

  modport master (
    output x_l, x_l_valid, x_r, x_r_valid,
    input  y_out, y_valid, y_ch, busy, overrun
  );

  modport slave (
    input  x_l, x_l_valid, x_r, x_r_valid,
    output y_out, y_valid, y_ch, busy, overrun
  );
endinterface
`default_nettype wire

// File: rtl/hb_dual_sched.sv
`default_nettype none
// ============================================================================
//  Module   : hb_dual_sched
//  Purpose  : Time-multiplexed controller for a 27-tap halfband
//             decimate-by-2 filter. One MAC engine serves the L and R
//             channels. Each channel has its own 32-entry circular sample
//             buffer. Output computations become due on every second sample
//             once the window is full. A round-robin arbiter assigns due
//             computations to the engine, and an 8-step symmetric MAC
//             sequence (7 coefficient pairs + centre tap) runs for each one.
//  Ports    : clk    system clock
//             reset  asynchronous, active-high reset
//             bus    hb_dual_sched_if.slave (samples in, results/status out)
//  Revision : 1.0  initial release
// ============================================================================
module hb_dual_sched (
  input  wire logic       clk,
  input  wire logic       reset,
  hb_dual_sched_if.slave  bus
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [4:0] c_fill_full  = 5'd27;  // taps in one window
  localparam logic [4:0] c_span       = 5'd26;  // distance first..last tap
  localparam logic [4:0] c_center_ofs = 5'd13;  // centre tap offset
  localparam logic [2:0] c_last_pair  = 3'd6;
  localparam int         c_center_sh  = 14;     // centre coefficient 2^14

  // Non-zero halfband coefficients, outermost pair first.
  function automatic logic signed [15:0] coef_of(input logic [2:0] k);
    case (k)
      3'd0:    coef_of = 16'sd3;
      3'd1:    coef_of = -16'sd25;
      3'd2:    coef_of = 16'sd117;
      3'd3:    coef_of = -16'sd394;
      3'd4:    coef_of = 16'sd1078;
      3'd5:    coef_of = -16'sd2753;
      default: coef_of = 16'sd10165;
    endcase
  endfunction

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_PAIR   = 2'd1,
    S_CENTER = 2'd2,
    S_OUT    = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // Per-channel state (index 0 = L, 1 = R)
  // --------------------------------------------------------------------------
  logic signed [15:0] r_buf [2][32];
  logic        [4:0]  r_wp      [2];
  logic        [4:0]  r_fill    [2];
  logic        [4:0]  r_due_ptr [2];
  logic        [1:0]  r_phase;
  logic        [1:0]  r_pending;
  logic        [1:0]  r_overrun;

  logic signed [15:0] w_x [2];
  logic        [1:0]  w_xv;
  logic        [4:0]  w_fill_inc [2];
  logic        [1:0]  w_due;

  // --------------------------------------------------------------------------
  // Engine state
  // --------------------------------------------------------------------------
  state_t             r_state;
  logic        [2:0]  r_k;
  logic signed [37:0] r_acc;
  logic        [4:0]  r_base;
  logic               r_ch;
  logic               r_last;      // last channel granted (1 = R)
  logic signed [15:0] r_y_out;
  logic               r_y_valid;
  logic               r_y_ch;
  logic               r_busy;

  logic               w_grant;
  logic               w_gch;
  logic        [4:0]  w_addr_a;
  logic        [4:0]  w_addr_b;
  logic        [4:0]  w_addr_c;
  logic signed [15:0] w_tap_a;
  logic signed [15:0] w_tap_b;
  logic signed [15:0] w_tap_c;
  logic signed [16:0] w_pair_sum;
  logic signed [32:0] w_pair_prod;
  logic signed [37:0] w_center_prod;
  logic signed [37:0] w_shift;
  logic signed [15:0] w_sat;

  assign w_x[0] = bus.x_l;
  assign w_x[1] = bus.x_r;
  assign w_xv   = {bus.x_r_valid, bus.x_l_valid};

  // --------------------------------------------------------------------------
  // Sample accept / due detection
  // A sample is due when it completes an even-numbered pair (phase was 1)
  // and the window, counting this sample, holds all 27 taps.
  // --------------------------------------------------------------------------
  always_comb begin
    for (int c = 0; c < 2; c++) begin
      w_fill_inc[c] = (r_fill[c] == c_fill_full) ? r_fill[c] : r_fill[c] + 5'd1;
      w_due[c]      = w_xv[c] && r_phase[c] && (w_fill_inc[c] >= c_fill_full);
    end
  end

  // The sample memory is not reset. The fill counter keeps stale entries out
  // of any window.
  always_ff @(posedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (w_xv[c]) begin
        r_buf[c][r_wp[c]] <= w_x[c];
      end
    end
  end

  // Pending/overrun bookkeeping. If a new due and a grant of the same
  // channel occur on the same edge, the new due wins. The grant has already
  // latched the previous due_ptr as its base.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < 2; c++) begin
        r_wp[c]      <= '0;
        r_fill[c]    <= '0;
        r_due_ptr[c] <= '0;
      end
      r_phase   <= '0;
      r_pending <= '0;
      r_overrun <= '0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (w_xv[c]) begin
          r_wp[c]    <= r_wp[c] + 5'd1;
          r_fill[c]  <= w_fill_inc[c];
          r_phase[c] <= ~r_phase[c];
        end
        if (w_due[c]) begin
          r_pending[c] <= 1'b1;
          r_due_ptr[c] <= r_wp[c];
          if (r_pending[c] && !(w_grant && (w_gch == 1'(c)))) begin
            r_overrun[c] <= 1'b1;
          end
        end else if (w_grant && (w_gch == 1'(c))) begin
          r_pending[c] <= 1'b0;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Round-robin arbiter. A grant is possible from IDLE, and also from OUT so
  // that back-to-back computations have no idle gap.
  // --------------------------------------------------------------------------
  assign w_grant = ((r_state == S_IDLE) || (r_state == S_OUT)) && (|r_pending);
  assign w_gch   = (&r_pending) ? ~r_last : r_pending[1];

  // --------------------------------------------------------------------------
  // MAC datapath. Pair k combines tap[2k] and tap[26-2k] around base b.
  // The 5-bit address arithmetic gives the modulo-32 wrap.
  // --------------------------------------------------------------------------
  assign w_addr_a = r_base - {1'b0, r_k, 1'b0};
  assign w_addr_b = r_base - c_span + {1'b0, r_k, 1'b0};
  assign w_addr_c = r_base - c_center_ofs;

  assign w_tap_a  = r_buf[r_ch][w_addr_a];
  assign w_tap_b  = r_buf[r_ch][w_addr_b];
  assign w_tap_c  = r_buf[r_ch][w_addr_c];

  assign w_pair_sum    = 17'(w_tap_a) + 17'(w_tap_b);
  assign w_pair_prod   = 33'(w_pair_sum) * 33'(coef_of(r_k));
  assign w_center_prod = 38'(w_tap_c) <<< c_center_sh;

  // Arithmetic shift floors toward -inf. The result is then clamped to Q15.
  assign w_shift = r_acc >>> 15;
  always_comb begin
    w_sat = w_shift[15:0];
    if (w_shift > 38'sd32767) begin
      w_sat = 16'sh7fff;
    end else if (w_shift < -38'sd32768) begin
      w_sat = -16'sh8000;
    end
  end

  // --------------------------------------------------------------------------
  // Sequencer
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_k       <= '0;
      r_acc     <= '0;
      r_base    <= '0;
      r_ch      <= 1'b0;
      r_last    <= 1'b1;
      r_y_out   <= '0;
      r_y_valid <= 1'b0;
      r_y_ch    <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_y_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_busy <= 1'b0;
        end
        S_PAIR: begin
          r_acc <= r_acc + 38'(w_pair_prod);
          if (r_k == c_last_pair) begin
            r_state <= S_CENTER;
          end else begin
            r_k <= r_k + 3'd1;
          end
        end
        S_CENTER: begin
          r_acc   <= r_acc + w_center_prod;
          r_state <= S_OUT;
        end
        S_OUT: begin
          r_y_out   <= w_sat;
          r_y_ch    <= r_ch;
          r_y_valid <= 1'b1;
          r_state   <= S_IDLE;
          r_busy    <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase

      // A grant overrides the IDLE/OUT assignments above.
      if (w_grant) begin
        r_base  <= r_due_ptr[w_gch];
        r_ch    <= w_gch;
        r_last  <= w_gch;
        r_acc   <= '0;
        r_k     <= '0;
        r_state <= S_PAIR;
        r_busy  <= 1'b1;
      end
    end
  end

  assign bus.y_out   = r_y_out;
  assign bus.y_valid = r_y_valid;
  assign bus.y_ch    = r_y_ch;
  assign bus.busy    = r_busy;
  assign bus.overrun = r_overrun;

endmodule
`default_nettype wire
